cordic_vectoring: RTL and testbench
===================================

# cordic_vectoring

Iterative CORDIC in vectoring mode: takes a signed Cartesian pair (x, y) and returns its phase angle and its magnitude. This block is the inverse of the SPWM rotation-mode sine generator. It shares the same 20-bit full-circle angle format, so a measured phase can be fed straight back into the SPWM angle path. It runs one micro-rotation per clock behind a start/busy/done handshake and holds its own arctangent table.

## Interface
- WIDTH, 16: width of the signed x_in and y_in inputs (range 8..24).
- ITER, 16: number of micro-rotations (range 8..18).
- clock  in  1: single system clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: request a conversion. Sampled only while busy=0.
- x_in  in  WIDTH: signed x operand, captured on the accepted start edge.
- y_in  in  WIDTH: signed y operand, captured on the accepted start edge.
- busy  out  1: high while a conversion is in progress.
- done  out  1: one-cycle pulse when angle_out and mag_out update.
- angle_out  out  20: phase angle.
  - Format: unsigned full circle, 2^20 = 360°.
  - Bits [19:18] give the quadrant, so 0x40000 = 90°, 0x80000 = 180° and 0xE0000 = 315° (-45°).
- mag_out  out  WIDTH+2: unsigned magnitude.

## Operation
- **Reset** (rst_n=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, angle_out=0, mag_out=0.
  - Internal x, y, z and the iteration counter are cleared.
- **States:** IDLE, ROT, and OUT (OUT exists only when gain compensation is compiled in).
- **IDLE:**
  - If start=1, capture and pre-rotate the operands into ROT (below), load z, clear the counter, and set busy=1.
  - If start=0, nothing changes.
- **Pre-rotation**, which brings the vector into the right half-plane. Internal x and y are WIDTH+2 bits signed.
  - x_in ≥ 0: x=x_in, y=y_in, z=0.
  - x_in < 0 and y_in ≥ 0: x=y_in, y=-x_in, z=0x40000.
  - x_in < 0 and y_in < 0: x=-y_in, y=x_in, z=0xC0000.
  - Negating -2^(WIDTH-1) is exact thanks to the 2-bit extension.
- **ROT**, iteration i = counter from 0 to ITER-1:
  - If y ≥ 0: x += y>>>i, y -= x>>>i, z += atan[i].
  - Otherwise: x -= y>>>i, y += x>>>i, z -= atan[i].
  - Shifts are arithmetic, and both updates use the old x and y.
  - z arithmetic is modulo 2^20 and wraps with no saturation.
- **atan table:** atan[i] = round(atan(2^-i)·2^19/π), a 20-bit constant ROM inside the block. atan[0]=131072, atan[1]=77376, atan[2]=40884.
- **After iteration ITER-1:**
  - angle_out=z and mag_out=x.
  - x is non-negative by construction and carries CORDIC gain K≈1.64676.
  - done=1 for one cycle, busy=0, state returns to IDLE.
- **Zero vector** (0, 0): angle_out=0, mag_out=0.
- **Outputs** hold their values until the next done.
- **start while busy=1** is ignored. Operands are not re-captured.
- **start in the same cycle as done:** busy is already 0, so it is accepted. This allows back-to-back conversions.

## Timing
- **Latency:** start is sampled at edge E0. Iterations occur at E1..E_ITER. done, angle_out and mag_out become visible after E_ITER.
  - Total is ITER clocks from the accepted start (16 at the default).
- **Throughput:** one result per ITER clocks.
- **busy** rises after E0 and falls together with the rise of done.
- **Reset mid-conversion:** the conversion is aborted immediately and all outputs return to their reset values. No done pulse is produced for the aborted request.
- **Accuracy:**
  - angle_out is within ±8 LSB of the true phase for |vector| ≥ 2^(WIDTH-4).
  - mag_out is within ±0.1% ±2 LSB of K·|v|, or of |v| when compensation is enabled.

## Configuration
- CORDIC_VEC_GAIN_COMP_EN
- **Defined:**
  - After ROT, the block enters OUT for one cycle.
  - mag_out = x·(2^-1 + 2^-3 - 2^-6 - 2^-9) ≈ 0.60742·x, implemented as shift-add with truncation.
  - Latency becomes ITER+1 clocks, and busy stays high through OUT.
- **Undefined:** mag_out is the raw x, including gain K. There is no OUT state.
- angle_out is identical in both builds.

## Test plan
- **Reset and idle:** hold rst_n=0, then release with start=0 for 20 cycles.
  - busy=0, done=0, angle_out=0 and mag_out=0 throughout.
- **Axis vectors** (WIDTH=16, ITER=16, no macro):
  - (10000, 0) gives angle ≈ 0 and mag ≈ 16468.
  - (0, 10000) gives angle ≈ 0x40000 and mag ≈ 16468.
  - (-10000, 0) gives angle ≈ 0x80000.
  - Each result arrives with done exactly 16 clocks after start.
- **Diagonals and extremes:**
  - (10000, -10000) gives angle ≈ 0xE0000 and mag ≈ 23289.
  - (-32768, -32768) gives angle ≈ 0xA0000 and mag ≈ 76312 with no overflow.
- **Handshake:**
  - start pulsed while busy=1 with different operands is ignored, and the result matches the first operands.
  - start asserted in the done cycle is accepted, and the second done arrives 16 clocks later.
- **Reset mid-operation:** assert rst_n=0 at iteration 7.
  - Outputs clear immediately, and no done pulse appears after release.
- **Gain compensation build:** with CORDIC_VEC_GAIN_COMP_EN defined, input (10000, 0).
  - mag_out ≈ 10000 ±12 and done arrives 17 clocks after start.

Source files
------------

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> phase (2^20 = full circle) and magnitude.
// Define CORDIC_VEC_GAIN_COMP_EN to add a one-cycle 1/K gain-compensation (OUT) stage.
module cordic_vectoring #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITER  = 16
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    busy,
  output logic                    done,
  output logic [19:0]             angle_out,
  output logic [WIDTH+1:0]        mag_out
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned CW = $clog2(ITER);

`ifdef CORDIC_VEC_GAIN_COMP_EN
  typedef enum logic [1:0] {StIdle, StRot, StOut} state_e;
`else
  typedef enum logic [0:0] {StIdle, StRot} state_e;
`endif

  // round(atan(2^-i) * 2^19 / pi)
  function automatic logic [19:0] atan_lut(input logic [4:0] i);
    logic [19:0] v;
    case (i)
      5'd0:    v = 20'd131072;
      5'd1:    v = 20'd77376;
      5'd2:    v = 20'd40884;
      5'd3:    v = 20'd20753;
      5'd4:    v = 20'd10417;
      5'd5:    v = 20'd5213;
      5'd6:    v = 20'd2607;
      5'd7:    v = 20'd1304;
      5'd8:    v = 20'd652;
      5'd9:    v = 20'd326;
      5'd10:   v = 20'd163;
      5'd11:   v = 20'd81;
      5'd12:   v = 20'd41;
      5'd13:   v = 20'd20;
      5'd14:   v = 20'd10;
      5'd15:   v = 20'd5;
      5'd16:   v = 20'd3;
      5'd17:   v = 20'd1;
      default: v = 20'd0;
    endcase
    return v;
  endfunction

  state_e               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic [19:0]          z_q, z_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 zero_q, zero_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [19:0]          angle_q, angle_d;
  logic [XW-1:0]        mag_q, mag_d;

  logic signed [XW-1:0] x_ext, y_ext, x_sh, y_sh, x_rot, y_rot;
  logic [19:0]          z_rot, atan_i;
  logic                 y_neg, last;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  logic signed [XW-1:0] mag_comp;
`endif

  always_comb begin
    x_ext  = {{2{x_in[WIDTH-1]}}, x_in};
    y_ext  = {{2{y_in[WIDTH-1]}}, y_in};
    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    y_neg  = y_q[XW-1];
    atan_i = atan_lut(5'(cnt_q));
    x_rot  = y_neg ? (x_q - y_sh) : (x_q + y_sh);
    y_rot  = y_neg ? (y_q + x_sh) : (y_q - x_sh);
    z_rot  = y_neg ? (z_q - atan_i) : (z_q + atan_i);
    last   = (cnt_q == CW'(ITER - 1));
`ifdef CORDIC_VEC_GAIN_COMP_EN
    // 2^-1 + 2^-3 - 2^-6 - 2^-9 ~= 1/K; x is non-negative here
    mag_comp = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
`endif

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    angle_d = angle_q;
    mag_d   = mag_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          // Pre-rotate into the right half-plane; the 2-bit extension makes negation exact
          if (!x_in[WIDTH-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = 20'h00000;
          end else if (!y_in[WIDTH-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = 20'h40000;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = 20'hC0000;
          end
          cnt_d   = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          busy_d  = 1'b1;
          state_d = StRot;
        end
      end
      StRot: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
          state_d = StOut;
`else
          angle_d = zero_q ? 20'h00000 : z_rot;
          mag_d   = x_rot;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
`endif
        end
      end
`ifdef CORDIC_VEC_GAIN_COMP_EN
      StOut: begin
        angle_d = zero_q ? 20'h00000 : z_q;
        mag_d   = mag_comp;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign angle_out = angle_q;
  assign mag_out   = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Self-checking bench for cordic_vectoring: directed table, handshake/reset sequences and
// random vectors against an ideal atan2/sqrt reference.
module tb_cordic_vectoring;

  localparam int unsigned W = 16;
  localparam int unsigned N = 16;
  localparam real PI = 3.14159265358979;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int unsigned LAT = N + 1;
  localparam real GAIN = 0.607421875;
  localparam int EXTRA_TOL = 4;
`else
  localparam int unsigned LAT = N;
  localparam real GAIN = 1.0;
  localparam int EXTRA_TOL = 0;
`endif

  logic                clock = 1'b0;
  logic                rst_n;
  logic                start;
  logic signed [W-1:0] x_in, y_in;
  logic                busy, done;
  logic [19:0]         angle_out;
  logic [W+1:0]        mag_out;

  int  vectors = 0;
  int  miscompares = 0;
  real k_cordic;

  cordic_vectoring #(.WIDTH(W), .ITER(N)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .angle_out (angle_out),
    .mag_out   (mag_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int ang;
    int mag;  // K*|v|, before any gain compensation
  } vec_t;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic real vmag(input int x, input int y);
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
  endfunction

  function automatic int ref_angle(input int x, input int y);
    real a;
    if (x == 0 && y == 0) return 0;
    a = $atan2(real'(y), real'(x));
    if (a < 0.0) a = a + 2.0 * PI;
    return $rtoi(a * 1048576.0 / (2.0 * PI) + 0.5) & 32'hFFFFF;
  endfunction

  // +-8 LSB plus one LSB of vector quantisation per micro-rotation
  function automatic int ang_tol(input int x, input int y);
    real m;
    m = vmag(x, y);
    if (m == 0.0) return 0;
    return 8 + $rtoi(real'(N) * 524288.0 / (PI * k_cordic * m));
  endfunction

  task automatic check_angle(input string name, input int act, input int req, input int tol);
    int d;
    d = (act - req) & 32'hFFFFF;
    if (d >= 524288) d = d - 1048576;
    if (d < 0) d = -d;
    check(name, d <= tol, act, req);
  endtask

  task automatic check_mag(input string name, input int act, input real req);
    real tol, d;
    tol = 0.001 * req + 2.0 + real'(N) + real'(EXTRA_TOL);
    d = real'(act) - req;
    if (d < 0.0) d = -d;
    check(name, d <= tol, act, $rtoi(req));
  endtask

  // Called #1 after a posedge; leaves the bench #1 after the accepting edge.
  task automatic start_op(input int x, input int y);
    x_in  = W'(x);
    y_in  = W'(y);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_rise", busy == 1'b1, busy, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!done && n < 200);
  endtask

  task automatic run(input string name, input int x, input int y, input int ang_req,
                     input real mag_req, input int atol);
    int n;
    logic [19:0]  pa;
    logic [W+1:0] pm;
    start_op(x, y);
    pa = angle_out;
    pm = mag_out;
    @(posedge clock);
    #1;
    check({name, "_hold"}, (angle_out == pa) && (mag_out == pm) && !done, angle_out, pa);
    wait_done(n);
    check({name, "_latency"}, (n + 1) == LAT, n + 1, LAT);
    check({name, "_busy_fall"}, busy == 1'b0, busy, 0);
    check_angle({name, "_angle"}, int'(angle_out), ang_req, atol);
    check_mag({name, "_mag"}, int'(mag_out), mag_req);
  endtask

  vec_t tab[7];

  initial begin
    int n, x, y;
    bit seen;
    logic [15:0] r;

    k_cordic = 1.0;
    for (int i = 0; i < int'(N); i++) k_cordic = k_cordic * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    tab[0] = '{10000, 0, 32'h00000, 16468};
    tab[1] = '{0, 10000, 32'h40000, 16468};
    tab[2] = '{-10000, 0, 32'h80000, 16468};
    tab[3] = '{10000, -10000, 32'hE0000, 23289};
    tab[4] = '{-32768, -32768, 32'hA0000, 76312};
    tab[5] = '{0, -10000, 32'hC0000, 16468};
    tab[6] = '{0, 0, 32'h00000, 0};

    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {busy, done} == 2'b00 && angle_out == 0 && mag_out == 0, angle_out, 0);
    @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("idle_%0d", i),
            {busy, done} == 2'b00 && angle_out == 0 && mag_out == 0, {busy, done}, 0);
    end

    for (int i = 0; i < 7; i++) begin
      run($sformatf("tab%0d", i), tab[i].x, tab[i].y, tab[i].ang,
          real'(tab[i].mag) * GAIN, ang_tol(tab[i].x, tab[i].y));
    end

    // start while busy with different operands must be ignored
    start_op(7000, 7000);
    repeat (3) @(posedge clock);
    #1;
    x_in  = W'(-20000);
    y_in  = W'(3000);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(n);
    check("ignore_latency", (n + 4) == LAT, n + 4, LAT);
    check_angle("ignore_angle", int'(angle_out), 32'h20000, ang_tol(7000, 7000));
    check_mag("ignore_mag", int'(mag_out), k_cordic * GAIN * vmag(7000, 7000));

    // back-to-back: run() leaves us in the done cycle, so the next start lands there
    run("b2b_a", -15000, 12000, ref_angle(-15000, 12000),
        k_cordic * GAIN * vmag(-15000, 12000), ang_tol(-15000, 12000));
    run("b2b_b", 20000, 5000, ref_angle(20000, 5000),
        k_cordic * GAIN * vmag(20000, 5000), ang_tol(20000, 5000));

    // reset part-way through a conversion
    start_op(-12345, -23456);
    repeat (7) @(posedge clock);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy == 1'b0, busy, 0);
    check("midrst_done", done == 1'b0, done, 0);
    check("midrst_angle", angle_out == 0, angle_out, 0);
    check("midrst_mag", mag_out == 0, mag_out, 0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check("midrst_no_done", seen == 1'b0, seen, 0);

    for (int i = 0; i < 40; i++) begin
      do begin
        r = 16'($urandom);
        x = int'($signed(r));
        r = 16'($urandom);
        y = int'($signed(r));
      end while (vmag(x, y) < 4096.0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
      run($sformatf("rnd%0d_(%0d,%0d)", i, x, y), x, y, ref_angle(x, y),
          k_cordic * GAIN * vmag(x, y), ang_tol(x, y));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
